wb_slave_router: RTL

WB_SLAVE_ROUTER -- requirements
Module: wb_slave_router

---
 rtl/wb_router_pkg.sv | 18 +
 rtl/wb_addr_decode.sv | 34 +++
 rtl/wb_slave_router.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_router_pkg.sv
// Shared definitions for the Wishbone slave router.
//
// Contents:
//   router_state_t - router FSM state encoding (StIdle, StWait, StResp)
//   ERR_DATA       - read data returned on a decode miss or slave timeout
//   ADDR_CMP_W     - width of the address field compared against each base entry
package wb_router_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } router_state_t;

    localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
    localparam int unsigned ADDR_CMP_W = 16;

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder for the Wishbone slave router.
//
// Compares the upper address field against every base entry and selects the
// lowest matching index, so overlapping entries resolve to the lowest slave.
// Entry 0 is the leftmost (most significant) field of SLV_BASE, which lets the
// table be written in slave order: {base0, base1, ...}.
//
// Ports:
//   adr_hi - address bits [31:16] of the incoming request
//   hit    - at least one entry matched
//   sel    - one-hot select of the winning slave (all zero on a miss)
module wb_addr_decode
    import wb_router_pkg::*;
#(
    parameter int unsigned                  N_SLV    = 2,
    parameter logic [N_SLV*ADDR_CMP_W-1:0] SLV_BASE = {16'h3000, 16'h3800}
) (
    input  logic [ADDR_CMP_W-1:0] adr_hi,
    output logic                  hit,
    output logic [N_SLV-1:0]      sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!hit && adr_hi == SLV_BASE[(N_SLV-1-i)*ADDR_CMP_W +: ADDR_CMP_W]) begin
                hit    = 1'b1;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_slave_router.sv
// Wishbone slave router: one upstream slave port fanned out to N_SLV
// downstream slaves, one outstanding transaction at a time.
//
// A request in IDLE is registered and decoded. A hit strobes the selected
// slave (WAIT) until it acks; a miss answers immediately with an error. The
// response is a single-cycle wbs_ack_o (RESP). Dropping wbs_cyc_i in WAIT
// aborts silently.
//
// Optional feature macro: WB_ROUTER_TIMEOUT_EN. When defined, WAIT is bounded
// to TIMEOUT cycles and then answered with an error; otherwise WAIT lasts until
// ack or abort and TIMEOUT is unused.
//
// Ports:
//   wb_clk_i, wb_rst_n            - clock, synchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i  - upstream request
//   wbs_ack_o, wbs_err_o          - response strobe and error qualifier
//   wbs_dat_o                     - read data (held outside RESP)
//   s_cyc_o, s_stb_o              - per-slave request strobes
//   s_we/sel/adr/dat_o            - broadcast registered request fields
//   s_ack_i, s_dat_i              - per-slave ack and read data (slave i at slice i)
module wb_slave_router
    import wb_router_pkg::*;
#(
    parameter int unsigned                  N_SLV       = 2,
    parameter int unsigned                  pDATA_WIDTH = 32,
    parameter logic [N_SLV*ADDR_CMP_W-1:0] SLV_BASE    = {16'h3000, 16'h3800},
    parameter int unsigned                  TIMEOUT     = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n,

    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [pDATA_WIDTH-1:0]       wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic [pDATA_WIDTH-1:0]       wbs_dat_o,

    output logic [N_SLV-1:0]             s_cyc_o,
    output logic [N_SLV-1:0]             s_stb_o,
    output logic                         s_we_o,
    output logic [3:0]                   s_sel_o,
    output logic [31:0]                  s_adr_o,
    output logic [pDATA_WIDTH-1:0]       s_dat_o,
    input  logic [N_SLV-1:0]             s_ack_i,
    input  logic [N_SLV*pDATA_WIDTH-1:0] s_dat_i
);

    router_state_t            state;
    logic                     req_we;
    logic [3:0]               req_sel;
    logic [31:0]              req_adr;
    logic [pDATA_WIDTH-1:0]   req_dat;
    logic [N_SLV-1:0]         slv_sel;

    logic                     dec_hit;
    logic [N_SLV-1:0]         dec_sel;
    logic                     sel_ack;
    logic [pDATA_WIDTH-1:0]   rd_data;

`ifdef WB_ROUTER_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // The counter holds the number of WAIT cycles already elapsed, so this
    // fires on the TIMEOUT-th cycle in WAIT.
    assign tmo_hit = (32'(tmo_cnt) + 32'd1) >= TIMEOUT;
`endif

    wb_addr_decode #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE)
    ) u_decode (
        .adr_hi (wbs_adr_i[31:32-ADDR_CMP_W]),
        .hit    (dec_hit),
        .sel    (dec_sel)
    );

    // Only the selected slave's ack counts; others are ignored.
    assign sel_ack = |(s_ack_i & slv_sel);

    // One-hot read data mux.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (slv_sel[i]) begin
                rd_data = rd_data | s_dat_i[i*pDATA_WIDTH +: pDATA_WIDTH];
            end
        end
    end

    assign s_we_o  = req_we;
    assign s_sel_o = req_sel;
    assign s_adr_o = req_adr;
    assign s_dat_o = req_dat;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state     <= StIdle;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            s_cyc_o   <= '0;
            s_stb_o   <= '0;
            req_we    <= 1'b0;
            req_sel   <= '0;
            req_adr   <= '0;
            req_dat   <= '0;
            slv_sel   <= '0;
`ifdef WB_ROUTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        req_we  <= wbs_we_i;
                        req_sel <= wbs_sel_i;
                        req_adr <= wbs_adr_i;
                        req_dat <= wbs_dat_i;
                        slv_sel <= dec_sel;
                        if (dec_hit) begin
                            s_cyc_o <= dec_sel;
                            s_stb_o <= dec_sel;
                            state   <= StWait;
`ifdef WB_ROUTER_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            // Decode miss: answer in the very next cycle.
                            wbs_ack_o <= 1'b1;
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= pDATA_WIDTH'(ERR_DATA);
                            state     <= StResp;
                        end
                    end
                end

                StWait: begin
                    if (!wbs_cyc_i) begin
                        // Master abort: no response, release the slave.
                        s_cyc_o <= '0;
                        s_stb_o <= '0;
                        state   <= StIdle;
                    end else if (sel_ack) begin
                        s_cyc_o   <= '0;
                        s_stb_o   <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_err_o <= 1'b0;
                        wbs_dat_o <= rd_data;
                        state     <= StResp;
                    end
`ifdef WB_ROUTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        s_cyc_o   <= '0;
                        s_stb_o   <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_err_o <= 1'b1;
                        wbs_dat_o <= pDATA_WIDTH'(ERR_DATA);
                        state     <= StResp;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                StResp: begin
                    wbs_ack_o <= 1'b0;
                    wbs_err_o <= 1'b0;
                    state     <= StIdle;
                end

                default: begin
                    s_cyc_o <= '0;
                    s_stb_o <= '0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule
